// File: rtl/router_fsm_np_if.sv
// router_fsm_np_if
// Handshake/status bundle between the router control FSM and its neighbours
// (input register block, output FIFO bank, synchroniser).
//   slave  : the FSM side (takes packet/FIFO status, drives state decodes)
//   master : the surrounding datapath / testbench side
// Signals:
//   pkt_valid, data_in[ADDR_W]        source packet valid, header address field
//   fifo_full, fifo_empty[NUM_PORTS]  selected-FIFO full, per-FIFO empty
//   soft_reset[NUM_PORTS]             per-FIFO read-timeout reset
//   parity_done, low_pkt_valid        register-block status
//   busy .. drop_pulse, dest_addr     FSM outputs
interface router_fsm_np_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
);
  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_pkt_valid;

  logic                 busy;
  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 write_enb_reg;
  logic                 rst_int_reg;
  logic                 drop_state;
  logic                 drop_pulse;
  logic [ADDR_W-1:0]    dest_addr;

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, drop_state, drop_pulse, dest_addr
  );

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, drop_state, drop_pulse, dest_addr
  );
endinterface

// File: rtl/router_fsm_np.sv
// router_fsm_np
// Control FSM for a NUM_PORTS-output router: header decode, first-data load,
// payload load, parity load, FIFO-full recovery, plus packet drop on an
// invalid header address or an empty-wait timeout, and per-destination soft
// reset. The destination is captured when the header is accepted and used for
// every later empty / soft-reset lookup.
// Ports:
//   clock   rising-edge system clock
//   resetn  asynchronous active-low reset
//   bus     router_fsm_np_if.slave (inputs from datapath, Moore state decodes
//           out, registered drop_pulse and dest_addr)
module router_fsm_np #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 30
) (
  input logic             clock,
  input logic             resetn,
  router_fsm_np_if.slave  bus
);

  localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
  localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
  localparam logic [3:0] LOAD_DATA          = 4'd2;
  localparam logic [3:0] LOAD_PARITY        = 4'd3;
  localparam logic [3:0] FIFO_FULL_STATE    = 4'd4;
  localparam logic [3:0] LOAD_AFTER_FULL    = 4'd5;
  localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd6;
  localparam logic [3:0] CHECK_PARITY_ERROR = 4'd7;
  localparam logic [3:0] DROP_PACKET        = 4'd8;

  localparam int NADDR = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [ADDR_W:0]  NP_L     = (ADDR_W + 1)'(NUM_PORTS);

  logic [3:0]        r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_dest;
  logic              r_drop_pulse;

  // Flags widened to the full address space so any ADDR_W-bit index is in
  // range; unused destinations read as not-empty / no soft reset.
  logic [NADDR-1:0]  w_empty_ext;
  logic [NADDR-1:0]  w_sr_ext;
  logic              w_hdr_ok;
  logic              w_soft_rst;

  always_comb begin
    w_empty_ext = '0;
    w_sr_ext    = '0;
    w_empty_ext[NUM_PORTS-1:0] = bus.fifo_empty;
    w_sr_ext[NUM_PORTS-1:0]    = bus.soft_reset;
  end

  assign w_hdr_ok   = ({1'b0, bus.data_in} < NP_L);
  // Only the soft reset of the packet's own destination matters, and only
  // once a packet is in flight.
  assign w_soft_rst = (r_state != DECODE_ADDRESS) && w_sr_ext[r_dest];

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      DECODE_ADDRESS: begin
        w_cnt_nxt = '0;
        if (bus.pkt_valid) begin
          if (!w_hdr_ok)                     w_next = DROP_PACKET;
          else if (w_empty_ext[bus.data_in]) w_next = LOAD_FIRST_DATA;
          else                               w_next = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: w_next = LOAD_DATA;
      WAIT_TILL_EMPTY: begin
        // Counter holds the number of completed wait cycles, so the state is
        // left after at most WAIT_TIMEOUT cycles.
        if (w_empty_ext[r_dest])    w_next = LOAD_FIRST_DATA;
        else if (r_cnt == CNT_LAST) w_next = DROP_PACKET;
        else                        w_cnt_nxt = r_cnt + 1'b1;
      end
      LOAD_DATA: begin
        if (bus.fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) w_next = LOAD_PARITY;
      end
      LOAD_PARITY:     w_next = CHECK_PARITY_ERROR;
      FIFO_FULL_STATE: if (!bus.fifo_full) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        w_next = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) w_next = LOAD_PARITY;
        else                        w_next = LOAD_DATA;
      end
      CHECK_PARITY_ERROR: w_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      DROP_PACKET:        if (!bus.pkt_valid) w_next = DECODE_ADDRESS;
      default:            w_next = DECODE_ADDRESS;
    endcase
    if (w_soft_rst) w_next = DECODE_ADDRESS;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= DECODE_ADDRESS;
      r_cnt        <= '0;
      r_dest       <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_nxt;
      r_drop_pulse <= (w_next == DROP_PACKET) && (r_state != DROP_PACKET);
      if (r_state == DECODE_ADDRESS && bus.pkt_valid) r_dest <= bus.data_in;
    end
  end

  assign bus.detect_add    = (r_state == DECODE_ADDRESS);
  assign bus.lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign bus.ld_state      = (r_state == LOAD_DATA);
  assign bus.laf_state     = (r_state == LOAD_AFTER_FULL);
  assign bus.full_state    = (r_state == FIFO_FULL_STATE);
  assign bus.rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign bus.drop_state    = (r_state == DROP_PACKET);
  assign bus.busy          = (r_state == LOAD_FIRST_DATA)   || (r_state == WAIT_TILL_EMPTY)
                          || (r_state == LOAD_PARITY)       || (r_state == FIFO_FULL_STATE)
                          || (r_state == LOAD_AFTER_FULL)   || (r_state == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY)
                          || (r_state == LOAD_AFTER_FULL);
  assign bus.drop_pulse    = r_drop_pulse;
  assign bus.dest_addr     = r_dest;

endmodule

// File: tb/tb_router_fsm_np.sv
module tb_router_fsm_np;
  localparam int NP = 3, AW = 2, WT = 30;
  localparam int DA = 0, LFD = 1, LD = 2, LP = 3, CPE = 4, FFS = 5, LAF = 6, WTE = 7, DRP = 8;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  router_fsm_np_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();
  router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(WT)) dut (
    .clock(clock), .resetn(resetn), .bus(bus));

  int n_chk = 0, n_err = 0, we_cnt = 0;
  logic [9:0] exp_q[$];

  // Expected outputs {busy,detect_add,lfd,ld,laf,full,we,rst_int,drop_state,drop_pulse}
  function automatic logic [9:0] ex(input int st, input bit pls);
    logic [9:0] v;
    v = '0;
    case (st)
      DA:  v[8] = 1'b1;
      LFD: begin v[9] = 1'b1; v[7] = 1'b1; end
      LD:  begin v[6] = 1'b1; v[3] = 1'b1; end
      LP:  begin v[9] = 1'b1; v[3] = 1'b1; end
      CPE: begin v[9] = 1'b1; v[2] = 1'b1; end
      FFS: begin v[9] = 1'b1; v[4] = 1'b1; end
      LAF: begin v[9] = 1'b1; v[5] = 1'b1; v[3] = 1'b1; end
      WTE: v[9] = 1'b1;
      DRP: v[1] = 1'b1;
      default: v = '0;
    endcase
    v[0] = pls;
    return v;
  endfunction

  function automatic logic [9:0] obs();
    return {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
            bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.drop_state, bus.drop_pulse};
  endfunction

  task automatic cmp(input string tag);
    logic [9:0] e, g;
    e = exp_q.pop_front();
    g = obs();
    n_chk++;
    assert (g === e) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, g, e);
    end
  endtask

  task automatic chk_dest(input string tag, input logic [AW-1:0] e);
    n_chk++;
    assert (bus.dest_addr === e) else begin
      n_err++;
      $error("FAIL %s dest observed=%0d expected=%0d", tag, bus.dest_addr, e);
    end
  endtask

  // Inputs are already set (at a negedge); push the expected post-edge
  // outputs, cross the edge, then compare on the next negedge.
  task automatic go(input string tag, input int st, input bit pls = 1'b0);
    exp_q.push_back(ex(st, pls));
    @(negedge clock);
    if (bus.write_enb_reg === 1'b1) we_cnt++;
    cmp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pkt_valid = 0; bus.data_in = '0; bus.fifo_full = 0; bus.fifo_empty = 3'b111;
    bus.soft_reset = '0; bus.parity_done = 0; bus.low_pkt_valid = 0;
    repeat (2) @(negedge clock);
    exp_q.push_back(ex(DA, 0)); cmp("reset_state");
    chk_dest("reset_dest", 2'd0);
    resetn = 1'b1;

    // Normal packet to port 2, 4 payload cycles
    bus.pkt_valid = 1; bus.data_in = 2'd2; go("t1_lfd", LFD);
    bus.data_in = 2'd1; we_cnt = 0;
    go("t1_ld1", LD); go("t1_ld2", LD); go("t1_ld3", LD); go("t1_ld4", LD);
    bus.pkt_valid = 0; go("t1_lp", LP);
    go("t1_cpe", CPE); go("t1_da", DA);
    chk_dest("t1_dest", 2'd2);
    n_chk++;
    assert (we_cnt == 5) else begin
      n_err++; $error("FAIL t1_we_cycles observed=%0d expected=5", we_cnt);
    end

    // Wait 10 cycles for port 1 to drain
    bus.fifo_empty = 3'b101; bus.pkt_valid = 1; bus.data_in = 2'd1;
    for (int i = 0; i < 10; i++) go("t2_wte", WTE);
    bus.fifo_empty = 3'b111; go("t2_lfd", LFD);
    go("t2_ld", LD);
    bus.pkt_valid = 0; go("t2_lp", LP); go("t2_cpe", CPE); go("t2_da", DA);
    chk_dest("t2_dest", 2'd1);

    // Port 0 never drains: timeout drop
    bus.fifo_empty = 3'b110; bus.pkt_valid = 1; bus.data_in = 2'd0;
    for (int i = 0; i < WT; i++) go("t3_wte", WTE);
    go("t3_drop_entry", DRP, 1'b1);
    go("t3_drop_hold", DRP); go("t3_drop_hold2", DRP);
    bus.pkt_valid = 0; go("t3_da", DA);
    bus.fifo_empty = 3'b111;

    // Invalid header address
    bus.pkt_valid = 1; bus.data_in = 2'd3; go("t4_drop_entry", DRP, 1'b1);
    go("t4_drop_hold", DRP);
    bus.pkt_valid = 0; go("t4_da", DA);
    chk_dest("t4_dest", 2'd3);

    // FIFO full for 3 cycles, low_pkt_valid on release
    bus.pkt_valid = 1; bus.data_in = 2'd0; go("t5_lfd", LFD); go("t5_ld", LD);
    bus.fifo_full = 1; go("t5_ffs1", FFS); go("t5_ffs2", FFS); go("t5_ffs3", FFS);
    bus.fifo_full = 0; bus.pkt_valid = 0; bus.low_pkt_valid = 1; go("t5_laf", LAF);
    go("t5_lp", LP);
    bus.low_pkt_valid = 0; go("t5_cpe", CPE); go("t5_da", DA);

    // Full on parity check, then parity_done out of LOAD_AFTER_FULL
    bus.pkt_valid = 1; bus.data_in = 2'd1; go("t5b_lfd", LFD); go("t5b_ld", LD);
    bus.pkt_valid = 0; go("t5b_lp", LP); go("t5b_cpe", CPE);
    bus.fifo_full = 1; go("t5b_ffs", FFS);
    bus.fifo_full = 0; go("t5b_laf", LAF);
    bus.parity_done = 1; go("t5b_da", DA);
    bus.parity_done = 0;

    // Soft reset: other port ignored, own port returns to decode
    bus.pkt_valid = 1; bus.data_in = 2'd2; go("t6_lfd", LFD); go("t6_ld", LD);
    bus.soft_reset = 3'b001; go("t6_sr_other", LD);
    bus.soft_reset = 3'b100; bus.pkt_valid = 0; go("t6_sr_own", DA);
    bus.soft_reset = 3'b000;

    // Async reset mid-LOAD_DATA
    bus.pkt_valid = 1; bus.data_in = 2'd1; go("t7_lfd", LFD); go("t7_ld", LD);
    #2 resetn = 1'b0;
    #1 exp_q.push_back(ex(DA, 0)); cmp("t7_async_reset");
    chk_dest("t7_dest_reset", 2'd0);
    @(negedge clock);
    resetn = 1'b1; bus.pkt_valid = 0; go("t7_after", DA);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
Parametrised next-generation router control FSM. Sequences header decode, first-data load, payload load, parity load and FIFO-full recovery for a router with NUM_PORTS output FIFOs. Added over the 3-port controller: a registered destination, invalid-address and wait-timeout packet drop, and per-destination soft reset. Sits between the router input register block (data path, parity) and the output FIFO bank/synchroniser.

Parameters:
NUM_PORTS, 3, number of output FIFOs/destinations (2..16)
ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_PORTS
WAIT_TIMEOUT, 30, cycles allowed in WAIT_TILL_EMPTY before the packet is dropped (>=1)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  source packet valid
data_in  in  ADDR_W  header address field (data_in[ADDR_W-1:0] of header byte)
fifo_full  in  1  full flag of currently selected FIFO
fifo_empty  in  NUM_PORTS  empty flag per FIFO
soft_reset  in  NUM_PORTS  per-FIFO read-timeout soft reset from synchroniser
parity_done  in  1  parity byte captured (register block)
low_pkt_valid  in  1  pkt_valid fell while FIFO full (register block)
busy  out  1  stall source
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
write_enb_reg  out  1  write enable to selected FIFO
rst_int_reg  out  1  in CHECK_PARITY_ERROR
drop_state  out  1  in DROP_PACKET
drop_pulse  out  1  one-cycle pulse on entry to DROP_PACKET
dest_addr  out  ADDR_W  registered destination of current packet

Behaviour:
- Reset (resetn low, async): state=DECODE_ADDRESS, dest_addr=0, wait counter=0, drop_pulse=0; hence detect_add=1, all other outputs 0.
- dest_addr loads data_in on the clock edge leaving DECODE_ADDRESS with pkt_valid=1; held constant until next DECODE_ADDRESS. All later empty/soft-reset checks use dest_addr, never live data_in.
- Outputs are Moore decodes of state (except drop_pulse, registered): busy=1 in LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR; 0 in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET. write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL only.
- Transitions (pkt_valid=1 required to leave DECODE_ADDRESS; otherwise stay):
  DECODE_ADDRESS: data_in>=NUM_PORTS -> DROP_PACKET; fifo_empty[data_in] -> LOAD_FIRST_DATA; else -> WAIT_TILL_EMPTY (counter cleared).
  LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
  WAIT_TILL_EMPTY: fifo_empty[dest_addr] -> LOAD_FIRST_DATA (priority); else counter increments; when counter==WAIT_TIMEOUT-1 and still not empty -> DROP_PACKET. Total dwell at most WAIT_TIMEOUT cycles.
  LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  LOAD_PARITY -> CHECK_PARITY_ERROR.
  FIFO_FULL_STATE: fifo_full -> stay; else -> LOAD_AFTER_FULL.
  LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
  CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  DROP_PACKET: !pkt_valid -> DECODE_ADDRESS; else stay (source streams unstalled, nothing written).
- Soft reset: soft_reset[dest_addr]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next edge (highest priority after resetn). soft_reset for other ports is ignored. In DECODE_ADDRESS soft_reset has no effect.
- drop_pulse=1 for exactly the first cycle in DROP_PACKET; 0 otherwise.
- Illegal state encodings -> DECODE_ADDRESS next edge.
- Async reset mid-packet: immediate return to reset values; no pulse generated.

Test Plan:
- NUM_PORTS=3, fifo_empty=3'b111, header data_in=2, 4 payload, pkt_valid drop -> states DA,LFD,LD x4,LP,CPE,DA; dest_addr=2; write_enb_reg high 5 cycles total (LD, LP).
- fifo_empty[1]=0 for 10 cycles then 1, header to port 1 -> busy high in WAIT_TILL_EMPTY 10 cycles, then LFD; no drop_pulse.
- fifo_empty[0]=0 permanently, WAIT_TIMEOUT=30, header to port 0 -> exactly 30 cycles in WAIT_TILL_EMPTY, drop_pulse single cycle, drop_state until pkt_valid low, then detect_add.
- Header data_in=3 with NUM_PORTS=3 -> DROP_PACKET directly, write_enb_reg never asserted.
- fifo_full=1 for 3 cycles in LOAD_DATA, low_pkt_valid=1 on release -> LD,FFS x3,LAF,LP,CPE,DA; full_state high 3 cycles.
- Packet to port 2 in LOAD_DATA, pulse soft_reset=3'b001 then 3'b100 -> first ignored, second returns to DECODE_ADDRESS next edge; resetn pulse mid-LOAD_DATA -> detect_add=1 asynchronously.
